// File: rtl/clk_div_ctrl_if.sv
// Handshake and status bundle between the clock-divider controller and its user.
// The master drives run control and configuration. The slave (the controller) reports status.
interface clk_div_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             running;
    logic             tick;
    logic             clk_div;
    logic [7:0]       period_cnt;

    modport master (
        output start, stop, cfg_valid, cfg_div,
        input  cfg_ready, running, tick, clk_div, period_cnt
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_div,
        output cfg_ready, running, tick, clk_div, period_cnt
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run/stop clock-divider controller: one tick per programmable period plus a flopped square wave.
// A ratio change that arrives mid-period is held in div_pend and takes effect at the next period boundary.
module clk_div_ctrl #(
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 125_000_000,
    parameter logic [CNT_W-1:0] MIN_DIV     = 2
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_div_act, w_div_act_nxt;
    logic [CNT_W-1:0] r_div_pend, w_div_pend_nxt;
    logic             r_clk_div;
    logic [7:0]       r_period_cnt;
    logic             w_running, w_tick, w_cfg_ready, w_cfg_acc;
    logic [CNT_W-1:0] w_cnt_inc, w_cfg_clamped;

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] r);
        return (r < MIN_DIV) ? MIN_DIV : r;
    endfunction

    assign w_running     = (r_state != S_IDLE);
    assign w_tick        = w_running && (r_cnt == r_div_act - CNT_W'(1));
    assign w_cfg_ready   = !rst && (r_state != S_PEND);
    assign w_cfg_acc     = bus.cfg_valid && w_cfg_ready;
    assign w_cnt_inc     = w_tick ? '0 : r_cnt + CNT_W'(1);
    assign w_cfg_clamped = clamp_div(bus.cfg_div);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_act_nxt  = r_div_act;
        w_div_pend_nxt = r_div_pend;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_cfg_acc) w_div_act_nxt = w_cfg_clamped;
                if (bus.start && !bus.stop) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cfg_acc) begin
                    // On a boundary cycle the new ratio can go live immediately.
                    if (w_tick) begin
                        w_div_act_nxt = w_cfg_clamped;
                    end else begin
                        w_div_pend_nxt = w_cfg_clamped;
                        w_state_nxt    = S_PEND;
                    end
                end
            end
            S_PEND: begin
                w_cnt_nxt = w_cnt_inc;
                if (bus.stop) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_div_act_nxt = r_div_pend;
                end else if (w_tick) begin
                    w_state_nxt   = S_RUN;
                    w_div_act_nxt = r_div_pend;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_div_act    <= DEFAULT_DIV;
            r_div_pend   <= '0;
            r_clk_div    <= 1'b0;
            r_period_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div_act  <= w_div_act_nxt;
            r_div_pend <= w_div_pend_nxt;
            // Computed from next-cycle state so that the square wave comes straight from a flop.
            r_clk_div  <= (w_state_nxt != S_IDLE) && (w_cnt_nxt < (w_div_act_nxt >> 1));
            if (w_tick) r_period_cnt <= r_period_cnt + 8'd1;
        end
    end

    assign bus.cfg_ready  = w_cfg_ready;
    assign bus.running    = w_running;
    assign bus.tick       = w_tick;
    assign bus.clk_div    = r_clk_div;
    assign bus.period_cnt = r_period_cnt;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl with DEFAULT_DIV=10: stimulus queues the expected periods,
// and the monitor checks each tick for period length, clk_div high cycles and period_cnt.
module tb_clk_div_ctrl;
    localparam int unsigned CNT_W = 32;

    typedef struct {
        int len;
        int high;
        int pcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nassert = 0;
    int   nfail = 0;
    exp_t exp_q[$];

    clk_div_ctrl_if #(.CNT_W(CNT_W)) ifc ();

    clk_div_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(32'd10),
        .MIN_DIV    (32'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nassert++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_periods(input int len, input int high, input int pcnt0, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{len, high, (pcnt0 + i) % 256});
    endtask

    task automatic cfg_idle(input int div);
        ifc.cfg_div   = div;
        ifc.cfg_valid = 1'b1;
        check("cfg_ready_idle", ifc.cfg_ready, 1);
        run_cycles(1);
        ifc.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        run_cycles(1);
        ifc.start = 1'b0;
    endtask

    task automatic pulse_stop();
        ifc.stop = 1'b1;
        run_cycles(1);
        ifc.stop = 1'b0;
    endtask

    // Monitor: measures each period between ticks and scores it against the queue.
    initial begin
        int   len;
        int   high;
        exp_t e;
        len  = 0;
        high = 0;
        forever begin
            @(negedge clk);
            if (!rst) check("tick_only_running", int'(ifc.tick & ~ifc.running), 0);
            if (rst || !ifc.running) begin
                len  = 0;
                high = 0;
            end else begin
                len++;
                if (ifc.clk_div) high++;
                if (ifc.tick) begin
                    if (exp_q.size() == 0) begin
                        check("tick_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("period_len", len, e.len);
                        check("clk_div_high", high, e.high);
                        check("period_cnt_at_tick", int'(ifc.period_cnt), e.pcnt);
                    end
                    len  = 0;
                    high = 0;
                end
            end
        end
    end

    initial begin
        ifc.start     = 1'b0;
        ifc.stop      = 1'b0;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_div   = '0;

        // Reset state
        rst = 1'b1;
        run_cycles(3);
        check("rst_cfg_ready", ifc.cfg_ready, 0);
        check("rst_running", ifc.running, 0);
        check("rst_tick", ifc.tick, 0);
        check("rst_clk_div", ifc.clk_div, 0);
        check("rst_period_cnt", int'(ifc.period_cnt), 0);
        rst = 1'b0;
        #1;
        check("cfg_ready_after_rst", ifc.cfg_ready, 1);

        // Default ratio: three 10-cycle periods
        push_periods(10, 5, 0, 3);
        pulse_start();
        check("running_after_start", ifc.running, 1);
        check("clk_div_after_start", ifc.clk_div, 1);
        run_cycles(30);
        check("period_cnt_30", int'(ifc.period_cnt), 3);
        pulse_stop();
        check("running_after_stop", ifc.running, 0);

        // Ratio 7 set in IDLE
        cfg_idle(7);
        push_periods(7, 3, 3, 2);
        pulse_start();
        run_cycles(14);
        pulse_stop();

        // Mid-period change 10 -> 4, with a stop on the last tick
        cfg_idle(10);
        push_periods(10, 5, 5, 1);
        push_periods(4, 2, 6, 2);
        pulse_start();
        run_cycles(3);
        ifc.cfg_div   = 4;
        ifc.cfg_valid = 1'b1;
        check("cfg_ready_run", ifc.cfg_ready, 1);
        run_cycles(1);
        ifc.cfg_valid = 1'b0;
        check("cfg_ready_pend", ifc.cfg_ready, 0);
        run_cycles(6);
        check("cfg_ready_back", ifc.cfg_ready, 1);
        run_cycles(7);
        pulse_stop();
        check("period_cnt_stop_tick", int'(ifc.period_cnt), 8);

        // Clamping: 0 in IDLE, 1 while running
        cfg_idle(0);
        push_periods(2, 1, 8, 2);
        pulse_start();
        run_cycles(4);
        ifc.cfg_div   = 1;
        ifc.cfg_valid = 1'b1;
        push_periods(2, 1, 10, 2);
        run_cycles(1);
        ifc.cfg_valid = 1'b0;
        check("cfg_ready_pend_min", ifc.cfg_ready, 0);
        run_cycles(3);
        pulse_stop();
        check("period_cnt_min", int'(ifc.period_cnt), 12);

        // stop + start + cfg in the same cycle at cnt=5
        cfg_idle(10);
        pulse_start();
        run_cycles(5);
        ifc.stop      = 1'b1;
        ifc.start     = 1'b1;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_div   = 3;
        run_cycles(1);
        ifc.stop      = 1'b0;
        ifc.start     = 1'b0;
        ifc.cfg_valid = 1'b0;
        check("combo_running", ifc.running, 0);
        check("combo_clk_div", ifc.clk_div, 0);
        check("combo_tick", ifc.tick, 0);
        check("combo_period_cnt", int'(ifc.period_cnt), 12);
        push_periods(10, 5, 12, 2);
        pulse_start();
        run_cycles(20);

        // Reset while a ratio change is pending
        ifc.cfg_div   = 5;
        ifc.cfg_valid = 1'b1;
        run_cycles(1);
        ifc.cfg_valid = 1'b0;
        check("pend_before_rst", ifc.cfg_ready, 0);
        rst = 1'b1;
        run_cycles(2);
        check("rst2_running", ifc.running, 0);
        check("rst2_clk_div", ifc.clk_div, 0);
        check("rst2_period_cnt", int'(ifc.period_cnt), 0);
        check("rst2_cfg_ready", ifc.cfg_ready, 0);
        rst = 1'b0;
        #1;
        check("rst2_cfg_ready_after", ifc.cfg_ready, 1);

        // 260 default periods: period_cnt wraps to 4
        push_periods(10, 5, 0, 260);
        pulse_start();
        run_cycles(2600);
        check("period_cnt_wrap", int'(ifc.period_cnt), 4);
        run_cycles(2);
        check("ticks_outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
